// File: rtl/reg_file_mp.sv
// reg_file_mp: parametrised multi-read-port register file for the MIPS datapath.
// After reset the array is swept one entry per clock to its init value
// (INIT_MODE 0 = zeros, 1 = entry index). The file only accepts writes
// once the sweep is done, which is signalled by ready.
//
// Handshake: ready is a registered level. A write (RegWrite=1) is accepted
// on a rising edge only while ready=1. A write while ready=0 is dropped and
// flagged on wr_drop for the following cycle. A write to register 0 while
// ready=1 is dropped and flagged on err_zero_wr for the following cycle.
// There is no backpressure beyond that: writers are expected to watch ready.
//
// Optional feature macro: REGFILE_BYPASS_EN adds write-first forwarding
// from the write port to every read port that addresses the same register.
module reg_file_mp #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int NUM_RD    = 2,
  parameter int INIT_MODE = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     RegWrite,
  input  logic [ADDR_W-1:0]        write_reg,
  input  logic [DATA_W-1:0]        write_data,
  input  logic [NUM_RD*ADDR_W-1:0] read_reg,
  output logic [NUM_RD*DATA_W-1:0] read_data,
  output logic                     ready,
  output logic                     err_zero_wr,
  output logic                     wr_drop
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    CLEAR = 2'b00,
    IDLE  = 2'b01
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   ptr;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [DATA_W-1:0]   wr_data;

  // Value loaded into an entry during the clear sweep; entry 0 is 0 either way.
  function automatic logic [DATA_W-1:0] init_val(input logic [ADDR_W-1:0] idx);
    if (INIT_MODE == 1) return DATA_W'(idx);
    else                return '0;
  endfunction

  // Control FSM: sweep pointer, ready level and the two error pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= CLEAR;
      ptr         <= '0;
      ready       <= 1'b0;
      err_zero_wr <= 1'b0;
      wr_drop     <= 1'b0;
    end else begin
      err_zero_wr <= 1'b0;
      wr_drop     <= 1'b0;
      unique case (state)
        CLEAR: begin
          wr_drop <= RegWrite;
          ptr     <= ptr + 1'b1;
          if (ptr == '1) begin
            state <= IDLE;
            ready <= 1'b1;
          end
        end
        IDLE: begin
          err_zero_wr <= RegWrite && (write_reg == '0);
        end
        default: begin
          state <= CLEAR;
          ptr   <= '0;
          ready <= 1'b0;
        end
      endcase
    end
  end

  // Select the single array write of this cycle: sweep entry or accepted write.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = write_reg;
    wr_data = write_data;
    if (!rst) begin
      if (state == CLEAR) begin
        wr_en   = 1'b1;
        wr_addr = ptr;
        wr_data = init_val(ptr);
      end else if (state == IDLE && RegWrite && write_reg != '0) begin
        wr_en = 1'b1;
      end
    end
  end

  // Storage array; no reset, contents are defined by the sweep.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Combinational read ports: zero while not ready and for register 0.
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd;
    assign ra = read_reg[k*ADDR_W +: ADDR_W];

    // Per-port read mux with optional write-first forwarding.
    always_comb begin
      rd = '0;
      if (ready && ra != '0) begin
        rd = mem[ra];
`ifdef REGFILE_BYPASS_EN
        if (RegWrite && write_reg == ra) rd = write_data;
`else
`endif
      end
    end

    assign read_data[k*DATA_W +: DATA_W] = rd;
  end

endmodule
